cla4b_add: RTL and testbench
============================

Name: cla4b_add

Overview:
- 4-bit carry-lookahead adder: a + b + cin, 5-bit result, flat (non-rippling) lookahead carry logic.
- Primary result is purely combinational, for single-cycle datapath use in the in-order single-issue processor.
- Also exports group propagate/generate for hierarchical CLA chaining.
- Provides an optional registered copy of the result, on one clock with async active-low reset.

Parameters:
- REG_OUT, 1: 1 = build registered outputs sum_q/cout_q; 0 = sum_q/cout_q tied to 0 and no flops inferred.

Ports:
- clk  input  1  rising-edge clock; used only by the registered outputs.
- rst_n  input  1  asynchronous active-low reset; clears the registered outputs only.
- a  input  4  operand A, unsigned.
- b  input  4  operand B, unsigned.
- cin  input  1  carry-in.
- sum  output  5  combinational a + b + cin; sum[4] is the carry-out.
- cout  output  1  combinational carry-out; always equal to sum[4].
- gp  output  1  group propagate = p3&p2&p1&p0.
- gg  output  1  group generate = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- sum_q  output  5  registered sum.
- cout_q  output  1  registered cout.

Behaviour:
- Bit terms: p_i = a_i ^ b_i, g_i = a_i & b_i, for i = 0..3.
- Carries: c0 = cin. Each carry is a flat two-level sum of products of g, p and cin, with no chained carry dependency:
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
  - c4 = gg | gp&c0
- Sum bits: sum[i] = p_i ^ c_i for i = 0..3; sum[4] = c4; cout = c4.
- Arithmetic: unsigned, no overflow. The 5-bit result is exact over the full range 0..31.
- Latency of sum/cout/gp/gg: zero cycles, purely combinational. Settles well within 1 ns of input change in simulation (no delays modelled).
- gp/gg are independent of cin.
- Registered path (REG_OUT=1):
  - sum_q <= sum and cout_q <= cout on every rising clk; no enable.
  - rst_n low asynchronously forces sum_q = 0 and cout_q = 0, held while low.
  - First capture is on the first rising clk after rst_n deasserts.
- Reset never affects sum, cout, gp or gg; they track the inputs continuously, including during reset.
- Reset mid-operation: registered outputs clear immediately. The combinational result is undisturbed.
- X/Z on inputs: no special handling; propagation is per the Boolean equations.
- Reset values: sum_q = 5'd0, cout_q = 0. Combinational outputs have no reset value.

Test Plan:
- a=0, b=0, cin=0 -> sum=0, cout=0, gp=0, gg=0.
- a=15, b=15, cin=1 -> sum=31, cout=1, gg=1, gp=0.
- a=15, b=0, cin=1 -> sum=16, cout=1, gp=1, gg=0. Full carry propagation through all four bits.
- a=9, b=6, cin=0 -> sum=15, cout=0, gp=1. Same operands with cin=1 -> sum=16, cout=1.
- 100 random vectors (a, b in 0..15, cin in 0..1), each checked 1 ns after applying inputs -> sum == a+b+cin exactly and cout == sum[4]. Zero mismatches required.
- Registered path:
  - Apply a=7, b=8, cin=1 with clocks running -> sum_q=16, cout_q=1 after the next rising edge.
  - Drop rst_n between edges -> sum_q=0, cout_q=0 immediately, while sum still reads 16.
  - Release rst_n -> sum_q=16 again after the next rising edge.

Source files
------------

// File: rtl/cla4b_add.sv
// 4-bit carry-lookahead adder with flat two-level carries, group P/G export
// for hierarchical chaining, and an optional registered copy of the result.
module cla4b_add #(
  parameter int REG_OUT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout,
  output logic       gp,
  output logic       gg,
  output logic [4:0] sum_q,
  output logic       cout_q
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is expanded down to g, p and cin so no carry waits on another.
  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gp = &p;
  assign gg = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign c[4] = gg | (gp & cin);

  assign sum  = {c[4], p ^ c[3:0]};
  assign cout = c[4];

  generate
    if (REG_OUT != 0) begin : g_reg
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
        end else begin
          sum_q  <= sum;
          cout_q <= cout;
        end
      end
    end else begin : g_noreg
      assign sum_q  = '0;
      assign cout_q = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cla4b_add.sv
// Self-checking bench for cla4b_add: directed corners, random vectors against
// an arithmetic reference, and the registered path including async reset.
module tb_cla4b_add;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [4:0] sum;
  logic       cout;
  logic       gp;
  logic       gg;
  logic [4:0] sum_q;
  logic       cout_q;

  int total = 0;
  int bad   = 0;

  cla4b_add #(.REG_OUT(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .gp     (gp),
    .gg     (gg),
    .sum_q  (sum_q),
    .cout_q (cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain integer addition. A group propagates when the operands
  // are bitwise complements (a+b == 15); it generates when a+b alone
  // overflows 4 bits.
  function automatic logic [4:0] ref_sum(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    int s;
    s = int'(x) + int'(y) + int'(ci);
    return s[4:0];
  endfunction

  function automatic logic ref_gp(input logic [3:0] x, input logic [3:0] y);
    return (int'(x) + int'(y)) == 15;
  endfunction

  function automatic logic ref_gg(input logic [3:0] x, input logic [3:0] y);
    return (int'(x) + int'(y)) > 15;
  endfunction

  task automatic apply(input logic [3:0] x, input logic [3:0] y, input logic ci);
    a   = x;
    b   = y;
    cin = ci;
    #1;
  endtask

  task automatic check_comb(input string name, input logic [4:0] esum,
                            input logic egp, input logic egg);
    total++;
    if (sum !== esum) begin
      bad++;
      $display("FAIL %s sum: got %0d want %0d (a=%0d b=%0d cin=%0d)", name, sum, esum, a, b, cin);
    end
    total++;
    if (cout !== esum[4]) begin
      bad++;
      $display("FAIL %s cout: got %b want %b", name, cout, esum[4]);
    end
    total++;
    if (gp !== egp) begin
      bad++;
      $display("FAIL %s gp: got %b want %b", name, gp, egp);
    end
    total++;
    if (gg !== egg) begin
      bad++;
      $display("FAIL %s gg: got %b want %b", name, gg, egg);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(4'd3, 4'd4, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sum_q !== 5'd0) begin
      bad++;
      $display("FAIL reset sum_q: got %0d want 0", sum_q);
    end
    total++;
    if (cout_q !== 1'b0) begin
      bad++;
      $display("FAIL reset cout_q: got %b want 0", cout_q);
    end
    // Combinational path must keep working while reset is held.
    check_comb("comb_in_reset", 5'd8, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_corners();
    apply(4'd0, 4'd0, 1'b0);   check_comb("zero", 5'd0, 1'b0, 1'b0);
    apply(4'd15, 4'd15, 1'b1); check_comb("max", 5'd31, 1'b0, 1'b1);
    apply(4'd15, 4'd0, 1'b1);  check_comb("ripple_all", 5'd16, 1'b1, 1'b0);
    apply(4'd9, 4'd6, 1'b0);   check_comb("prop_cin0", 5'd15, 1'b1, 1'b0);
    apply(4'd9, 4'd6, 1'b1);   check_comb("prop_cin1", 5'd16, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] x;
    logic [3:0] y;
    logic       ci;
    for (int i = 0; i < 100; i++) begin
      x  = 4'($urandom_range(15));
      y  = 4'($urandom_range(15));
      ci = 1'($urandom_range(1));
      apply(x, y, ci);
      check_comb("random", ref_sum(x, y, ci), ref_gp(x, y), ref_gg(x, y));
    end
  endtask

  task automatic check_reg(input string name, input logic [4:0] esum);
    total++;
    if (sum_q !== esum) begin
      bad++;
      $display("FAIL %s sum_q: got %0d want %0d", name, sum_q, esum);
    end
    total++;
    if (cout_q !== esum[4]) begin
      bad++;
      $display("FAIL %s cout_q: got %b want %b", name, cout_q, esum[4]);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    apply(4'd7, 4'd8, 1'b1);
    @(posedge clk);
    #1;
    check_reg("reg_capture", 5'd16);
    // Assert reset between edges: flops clear at once, comb result stays.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reg("reg_async_clear", 5'd0);
    total++;
    if (sum !== 5'd16) begin
      bad++;
      $display("FAIL reset_mid sum: got %0d want 16", sum);
    end
    @(posedge clk);
    #1;
    check_reg("reg_held_in_reset", 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reg("reg_before_edge", 5'd0);
    @(posedge clk);
    #1;
    check_reg("reg_after_release", 5'd16);
  endtask

  task automatic test_back_to_back();
    logic [4:0] prev;
    logic [3:0] x;
    logic [3:0] y;
    logic       ci;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      x  = 4'($urandom_range(15));
      y  = 4'($urandom_range(15));
      ci = 1'($urandom_range(1));
      apply(x, y, ci);
      prev = ref_sum(x, y, ci);
      @(posedge clk);
      #1;
      check_reg("b2b", prev);
    end
  endtask

  initial begin
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_corners();
    test_random();
    test_registered();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
